ysyx_22040210_axi_rd_arbiter: RTL and testbench

YSYX_22040210_AXI_RD_ARBITER -- requirements
Module: ysyx_22040210_axi_rd_arbiter

---
 rtl/ysyx_22040210_axi_rd_arbiter_pkg.sv | 26 ++
 rtl/ysyx_22040210_axi_rd_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22040210_axi_rd_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040210_axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040210_axi_rd_arbiter_pkg
// Description : Shared constants and the state encoding for the AXI read
//               arbiter that sits between the icache/dcache and the AXI
//               master read channels.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22040210_axi_rd_arbiter_pkg;

    // AXI IDs that tag each burst with its owner.
    localparam logic [3:0] IC_ID      = 4'd0;
    localparam logic [3:0] DC_ID      = 4'd1;

    // INCR burst type and the fixed icache beat size (8 bytes per beat).
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] IC_SIZE    = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

endpackage : ysyx_22040210_axi_rd_arbiter_pkg
`default_nettype wire

// File: rtl/ysyx_22040210_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22040210_axi_rd_arbiter
// Description : Two-requester (icache / dcache) AXI read arbiter. One burst
//               is outstanding at a time; contention is resolved round-robin
//               (the loser of the last contention wins next, dcache first
//               after reset). Read beats are forwarded with zero latency and
//               tagged with the owner and a protocol-error flag.
// Ports       : clk, rst (sync, active-low)
//               ic_req_* / dc_req_*   : request side, req_ready = accept pulse
//               ic_resp_valid / dc_resp_valid, resp_data/last/err : beat out
//               io_master_ar*         : AXI read-address channel
//               io_master_r*          : AXI read-data channel
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040210_axi_rd_arbiter
    import ysyx_22040210_axi_rd_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        ic_req_valid,
    output logic        ic_req_ready,
    input  logic [31:0] ic_req_addr,
    input  logic [7:0]  ic_req_len,
    output logic        ic_resp_valid,

    input  logic        dc_req_valid,
    output logic        dc_req_ready,
    input  logic [31:0] dc_req_addr,
    input  logic [7:0]  dc_req_len,
    input  logic [2:0]  dc_req_size,
    output logic        dc_resp_valid,

    output logic [63:0] resp_data,
    output logic        resp_last,
    output logic        resp_err,

    output logic        io_master_arvalid,
    input  logic        io_master_arready,
    output logic [3:0]  io_master_arid,
    output logic [31:0] io_master_araddr,
    output logic [7:0]  io_master_arlen,
    output logic [2:0]  io_master_arsize,
    output logic [1:0]  io_master_arburst,
    input  logic        io_master_rvalid,
    output logic        io_master_rready,
    input  logic [3:0]  io_master_rid,
    input  logic [63:0] io_master_rdata,
    input  logic [1:0]  io_master_rresp,
    input  logic        io_master_rlast
);

    arb_state_t  r_state;
    logic        r_owner_dc;    // owner of the outstanding burst
    logic        r_prio_dc;     // dcache wins the next contention
    logic [7:0]  r_beat_cnt;
    logic        r_arvalid;
    logic        r_rready;
    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [2:0]  r_arsize;

    logic        w_idle;
    logic        w_contend;
    logic        w_grant_dc;
    logic        w_grant_ic;
    logic        w_beat;
    logic        w_err;

    // ------------------------------------------------------------------
    // Grant decision (only meaningful in IDLE)
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == ST_IDLE);
    assign w_contend  = ic_req_valid & dc_req_valid;
    assign w_grant_dc = w_idle & dc_req_valid & (~ic_req_valid | r_prio_dc);
    assign w_grant_ic = w_idle & ic_req_valid & ~w_grant_dc;

    // Outputs are forced low while reset is held so that a burst in flight
    // is cut off immediately, not one edge later.
    assign ic_req_ready = rst & w_grant_ic;
    assign dc_req_ready = rst & w_grant_dc;

    // ------------------------------------------------------------------
    // Beat forwarding and checking
    // ------------------------------------------------------------------
    assign w_beat = rst & (r_state == ST_DATA) & io_master_rvalid;

    // A beat is bad if the slave flags it, it carries someone else's ID,
    // or rlast disagrees with the beat count in either direction.
    assign w_err = (io_master_rresp != 2'b00)
                 | (io_master_rid != r_arid)
                 | ( io_master_rlast & (r_beat_cnt != r_arlen))
                 | (~io_master_rlast & (r_beat_cnt == r_arlen));

    assign ic_resp_valid = w_beat & ~r_owner_dc;
    assign dc_resp_valid = w_beat &  r_owner_dc;
    assign resp_data     = rst ? io_master_rdata : 64'd0;
    assign resp_last     = w_beat & io_master_rlast;
    assign resp_err      = w_beat & w_err;

    assign io_master_arvalid = rst & r_arvalid;
    assign io_master_rready  = rst & r_rready;
    assign io_master_arid    = r_arid;
    assign io_master_araddr  = r_araddr;
    assign io_master_arlen   = r_arlen;
    assign io_master_arsize  = r_arsize;
    assign io_master_arburst = BURST_INCR;

    // ------------------------------------------------------------------
    // FSM with registered AR/R handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner_dc <= 1'b0;
            r_prio_dc  <= 1'b1;
            r_beat_cnt <= 8'd0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_arid     <= 4'd0;
            r_araddr   <= 32'd0;
            r_arlen    <= 8'd0;
            r_arsize   <= IC_SIZE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dc) begin
                        r_owner_dc <= 1'b1;
                        r_arid     <= DC_ID;
                        r_araddr   <= dc_req_addr;
                        r_arlen    <= dc_req_len;
                        r_arsize   <= dc_req_size;
                        r_arvalid  <= 1'b1;
                        r_state    <= ST_ADDR;
                    end else if (w_grant_ic) begin
                        r_owner_dc <= 1'b0;
                        r_arid     <= IC_ID;
                        r_araddr   <= ic_req_addr;
                        r_arlen    <= ic_req_len;
                        r_arsize   <= IC_SIZE;
                        r_arvalid  <= 1'b1;
                        r_state    <= ST_ADDR;
                    end
                    // Priority moves only when both competed: the loser
                    // of this contention gets the next one.
                    if (w_contend) begin
                        r_prio_dc <= w_grant_ic;
                    end
                end
                ST_ADDR: begin
                    if (io_master_arready) begin
                        r_arvalid  <= 1'b0;
                        r_rready   <= 1'b1;
                        r_beat_cnt <= 8'd0;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (io_master_rvalid) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (io_master_rlast) begin
                            r_rready <= 1'b0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : ysyx_22040210_axi_rd_arbiter
`default_nettype wire

// File: tb/tb_ysyx_22040210_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22040210_axi_rd_arbiter
// Description : Self-checking bench for the AXI read arbiter. Burst vectors
//               come from a table; forwarded beats are checked against a
//               scoreboard queue filled as the AXI slave side is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040210_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [31:0] ic_req_addr;
    logic [7:0]  ic_req_len;
    logic        dc_req_valid, dc_req_ready, dc_resp_valid;
    logic [31:0] dc_req_addr;
    logic [7:0]  dc_req_len;
    logic [2:0]  dc_req_size;
    logic [63:0] resp_data;
    logic        resp_last, resp_err;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  arid, rid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic [63:0] rdata;

    always #5 clk = ~clk;

    ysyx_22040210_axi_rd_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .ic_req_valid      (ic_req_valid),
        .ic_req_ready      (ic_req_ready),
        .ic_req_addr       (ic_req_addr),
        .ic_req_len        (ic_req_len),
        .ic_resp_valid     (ic_resp_valid),
        .dc_req_valid      (dc_req_valid),
        .dc_req_ready      (dc_req_ready),
        .dc_req_addr       (dc_req_addr),
        .dc_req_len        (dc_req_len),
        .dc_req_size       (dc_req_size),
        .dc_resp_valid     (dc_resp_valid),
        .resp_data         (resp_data),
        .resp_last         (resp_last),
        .resp_err          (resp_err),
        .io_master_arvalid (arvalid),
        .io_master_arready (arready),
        .io_master_arid    (arid),
        .io_master_araddr  (araddr),
        .io_master_arlen   (arlen),
        .io_master_arsize  (arsize),
        .io_master_arburst (arburst),
        .io_master_rvalid  (rvalid),
        .io_master_rready  (rready),
        .io_master_rid     (rid),
        .io_master_rdata   (rdata),
        .io_master_rresp   (rresp),
        .io_master_rlast   (rlast)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        dc;
        logic [63:0] data;
        logic        last;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        dc;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          delay;     // cycles arready is held low
        int          nbeats;    // beats actually returned
        int          bad_beat;  // beat index carrying bad_resp (-1 none)
        logic [1:0]  bad_resp;
        int          rid_beat;  // beat index carrying a wrong rid (-1 none)
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Beat monitor: every forwarded beat must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (ic_resp_valid === 1'b1 || dc_resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got ic=%b dc=%b want no beat", ic_resp_valid, dc_resp_valid);
            end else begin
                e = sb.pop_front();
                check("beat_dc_valid", dc_resp_valid, e.dc);
                check("beat_ic_valid", ic_resp_valid, !e.dc);
                check("beat_data", resp_data, e.data);
                check("beat_last", resp_last, e.last);
                check("beat_err", resp_err, e.err);
            end
        end
    end

    // Precondition: called at a negedge with the requester(s) already valid.
    task automatic do_grant(input logic exp_dc);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (ic_req_ready === 1'b1 || dc_req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no ready want %s", exp_dc ? "dc" : "ic");
        end else begin
            check("grant_dc_ready", dc_req_ready, exp_dc);
            check("grant_ic_ready", ic_req_ready, !exp_dc);
        end
        @(posedge clk); #1;
        if (exp_dc) dc_req_valid = 1'b0;
        else        ic_req_valid = 1'b0;
        @(negedge clk);
        check("ready_after_grant", {ic_req_ready, dc_req_ready}, 2'b00);
    endtask

    // Precondition: at the negedge of the first cycle after the grant.
    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input int delay);
        check("rready_in_addr", rready, 1'b0);
        for (int c = 0; c <= delay; c++) begin
            if (c > 0) @(negedge clk);
            check("ar_fields", {arvalid, arid, araddr, arlen, arsize, arburst},
                  {1'b1, id, addr, len, size, 2'b01});
            if (c == delay) arready = 1'b1;
        end
        @(posedge clk); #1;
        arready = 1'b0;
        @(negedge clk);
        check("handshake_done", {arvalid, rready}, 2'b01);
    endtask

    // Precondition: at a negedge in the first DATA cycle.
    task automatic do_data(input logic dc, input logic [3:0] id, input logic [7:0] len,
                           input int nbeats, input int bad_beat, input logic [1:0] bad_resp,
                           input int rid_beat);
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            @(posedge clk); #1;
            rvalid = 1'b1;
            rid    = (b == rid_beat) ? (id ^ 4'h3) : id;
            rdata  = {$urandom, $urandom};
            rresp  = (b == bad_beat) ? bad_resp : 2'b00;
            rlast  = (b == nbeats - 1);
            e.dc   = dc;
            e.data = rdata;
            e.last = rlast;
            e.err  = (rresp != 2'b00) || (rid != id) ||
                     (rlast && b != int'(len)) || (!rlast && b == int'(len));
            sb.push_back(e);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        @(negedge clk);
        check("rready_after_last", rready, 1'b0);
        check("beats_delivered", sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        if (v.dc) begin
            dc_req_valid = 1'b1;
            dc_req_addr  = v.addr;
            dc_req_len   = v.len;
            dc_req_size  = v.size;
        end else begin
            ic_req_valid = 1'b1;
            ic_req_addr  = v.addr;
            ic_req_len   = v.len;
        end
        @(negedge clk);
        do_grant(v.dc);
        do_ar(v.dc ? 4'd1 : 4'd0, v.addr, v.len, v.dc ? v.size : 3'b011, v.delay);
        do_data(v.dc, v.dc ? 4'd1 : 4'd0, v.len, v.nbeats, v.bad_beat, v.bad_resp, v.rid_beat);
    endtask

    initial begin
        //           dc    addr           len   size  dly nb  badb resp   ridb
        vecs[0] = '{1'b0, 32'h8000_0000, 8'd3, 3'd3, 0, 4, -1, 2'b00, -1};  // icache refill
        vecs[1] = '{1'b1, 32'h1000_0004, 8'd0, 3'd2, 5, 1, -1, 2'b00, -1};  // uncached, slow AR
        vecs[2] = '{1'b0, 32'h8000_0100, 8'd3, 3'd3, 0, 4,  1, 2'b10, -1};  // bad rresp beat 2
        vecs[3] = '{1'b0, 32'h8000_0200, 8'd3, 3'd3, 1, 2, -1, 2'b00, -1};  // early rlast
        vecs[4] = '{1'b1, 32'h8000_1000, 8'd7, 3'd3, 2, 8, -1, 2'b00,  3};  // wrong rid
        vecs[5] = '{1'b1, 32'h8000_2000, 8'd1, 3'd3, 0, 3, -1, 2'b00, -1};  // rlast late

        rst = 1'b0;
        ic_req_valid = 1'b0; ic_req_addr = 32'd0; ic_req_len = 8'd0;
        dc_req_valid = 1'b0; dc_req_addr = 32'd0; dc_req_len = 8'd0; dc_req_size = 3'd0;
        arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rresp = 2'b00; rlast = 1'b0;
        rdata = 64'hDEAD_BEEF_CAFE_F00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, resp_last, resp_err,
               arvalid, rready, arid, araddr, arlen, arsize, arburst},
              {8'b0, 4'd0, 32'd0, 8'd0, 3'b011, 2'b01});
        check("reset_resp_data", resp_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        rdata = 64'd0;

        // Round-robin contention: both kept busy so every grant contends.
        @(posedge clk); #1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h8000_3000; ic_req_len = 8'd1;
        dc_req_valid = 1'b1; dc_req_addr = 32'h8000_4000; dc_req_len = 8'd1; dc_req_size = 3'd3;
        @(negedge clk);
        do_grant(1'b1);
        do_ar(4'd1, 32'h8000_4000, 8'd1, 3'd3, 0);
        dc_req_valid = 1'b1; dc_req_addr = 32'h8000_5000; dc_req_len = 8'd0; dc_req_size = 3'd2;
        do_data(1'b1, 4'd1, 8'd1, 2, -1, 2'b00, -1);
        do_grant(1'b0);
        do_ar(4'd0, 32'h8000_3000, 8'd1, 3'd3, 0);
        ic_req_valid = 1'b1; ic_req_addr = 32'h8000_6000; ic_req_len = 8'd0;
        do_data(1'b0, 4'd0, 8'd1, 2, -1, 2'b00, -1);
        do_grant(1'b1);
        do_ar(4'd1, 32'h8000_5000, 8'd0, 3'd2, 0);
        do_data(1'b1, 4'd1, 8'd0, 1, -1, 2'b00, -1);
        do_grant(1'b0);
        do_ar(4'd0, 32'h8000_6000, 8'd0, 3'd3, 0);
        do_data(1'b0, 4'd0, 8'd0, 1, -1, 2'b00, -1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset during beat 1 of a burst: nothing more may be forwarded.
        @(posedge clk); #1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h8000_7000; ic_req_len = 8'd3;
        @(negedge clk);
        do_grant(1'b0);
        do_ar(4'd0, 32'h8000_7000, 8'd3, 3'd3, 0);
        @(posedge clk); #1;
        rst = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 64'h1234_5678_9ABC_DEF0; rlast = 1'b0;
        @(negedge clk);
        check("rst_mid_burst", {rready, ic_resp_valid, dc_resp_valid}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("after_rst_release", {arvalid, rready, ic_resp_valid, dc_resp_valid}, 4'b0000);
        @(posedge clk); #1;
        rvalid = 1'b0;
        run_vec(vecs[0]);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ysyx_22040210_axi_rd_arbiter
`default_nettype wire
